pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and arbitration helpers for the pipeline stall/flush controller.
// The cause with the highest priority rank decides the pipeline register controls.
package pipe_ctrl_pkg;

   typedef enum logic {RUN, MD_BUSY} state_t;

   typedef enum logic [2:0] {NONE, MEM, MD, LOAD_USE, BRANCH} stall_cause_t;

   localparam int unsigned PRIO_NONE     = 0;
   localparam int unsigned PRIO_LOAD_USE = 1;
   localparam int unsigned PRIO_BRANCH   = 2;
   localparam int unsigned PRIO_MD       = 3;
   localparam int unsigned PRIO_MEM      = 4;

   function automatic int unsigned cause_prio(input stall_cause_t c);
      case (c)
         MEM:      return PRIO_MEM;
         MD:       return PRIO_MD;
         BRANCH:   return PRIO_BRANCH;
         LOAD_USE: return PRIO_LOAD_USE;
         default:  return PRIO_NONE;
      endcase
   endfunction

   function automatic stall_cause_t pick_cause(input logic mem, input logic md,
                                               input logic br, input logic lu);
      stall_cause_t best;
      best = NONE;
      if (lu  && cause_prio(LOAD_USE) > cause_prio(best)) best = LOAD_USE;
      if (br  && cause_prio(BRANCH)   > cause_prio(best)) best = BRANCH;
      if (md  && cause_prio(MD)       > cause_prio(best)) best = MD;
      if (mem && cause_prio(MEM)      > cause_prio(best)) best = MEM;
      return best;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait, mul/div
// occupancy of EX, taken-branch flush and load-use bubble, plus a stall counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MD_CYCLES  = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_mem_read,
   input  logic                  ex_branch_taken,
   input  logic                  ex_md_start,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   input  logic                  stat_clr,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  idex_en,
   output logic                  exmem_en,
   output logic                  memwb_en,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  exmem_flush,
   output logic                  memwb_flush,
   output logic                  md_busy,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int MD_CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
   localparam bit MD_EN    = (MD_CYCLES > 1);
   // The start cycle is itself a stall, so the counter covers the remaining MD_CYCLES-2.
   localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'((MD_CYCLES > 1) ? MD_CYCLES - 2 : 0);

   state_t                state, state_nxt;
   logic [MD_CNT_W-1:0]   md_cnt, md_cnt_nxt;
   logic                  mem_stall, load_use, md_req;
   stall_cause_t          cause;
   logic                  stall_inc;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      mem_stall = mem_req & ~mem_ready;
      load_use  = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      md_req    = (state == RUN) ? (ex_md_start && MD_EN) : (md_cnt != '0);
      cause     = pick_cause(mem_stall, md_req,
                             (state == RUN) && ex_branch_taken,
                             (state == RUN) && load_use);

      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      case (state)
         RUN: begin
            if (cause == MD) begin
               state_nxt  = MD_BUSY;
               md_cnt_nxt = MD_LOAD;
            end
         end
         MD_BUSY: begin
            // Counting continues under a memory wait; only the exit waits for it.
            if (md_cnt != '0)
               md_cnt_nxt = md_cnt - 1'b1;
            else if (!mem_stall)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      case (cause)
         MEM: begin
            pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0; exmem_en = 1'b0;
            memwb_flush = 1'b1;
         end
         MD: begin
            pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0;
            exmem_flush = 1'b1;
         end
         BRANCH: begin
            ifid_flush = 1'b1; idex_flush = 1'b1;
         end
         LOAD_USE: begin
            pc_en = 1'b0; ifid_en = 1'b0;
            idex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   assign md_busy   = (state == MD_BUSY);
   assign stall_inc = (cause == MEM) || (cause == MD) || (cause == LOAD_USE);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .resetN (resetN),
      .inc    (stall_inc),
      .clr    (stat_clr),
      .cnt    (stall_cnt)
   );

   md_branch_excl: assert property (@(posedge clk) disable iff (!resetN)
                                    !(ex_md_start && ex_branch_taken));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a cycle-level rule model checked every cycle plus
// directed literal expectations; a second instance covers MD_CYCLES=1.
module tb_pipe_hazard_ctrl;

   localparam int MDC  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic resetN = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic id_uses_rt = 0, ex_mem_read = 0, ex_branch_taken = 0, ex_md_start = 0;
   logic mem_req = 0, mem_ready = 0, stat_clr = 0;

   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy;
   logic [CW-1:0] stall_cnt;

   logic d1_pc_en, d1_ifid_en, d1_idex_en, d1_exmem_en, d1_memwb_en;
   logic d1_ifid_flush, d1_idex_flush, d1_exmem_flush, d1_memwb_flush, d1_md_busy;
   logic [CW-1:0] d1_stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_CYCLES(MDC), .CNT_W(CW)) dut (
      .clk(clk), .resetN(resetN), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .ex_md_start(ex_md_start), .mem_req(mem_req), .mem_ready(mem_ready),
      .stat_clr(stat_clr), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .md_busy(md_busy), .stall_cnt(stall_cnt));

   pipe_hazard_ctrl #(.REG_ADDR_W(5), .MD_CYCLES(1), .CNT_W(CW)) dut1 (
      .clk(clk), .resetN(resetN), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .ex_md_start(ex_md_start), .mem_req(mem_req), .mem_ready(mem_ready),
      .stat_clr(stat_clr), .pc_en(d1_pc_en), .ifid_en(d1_ifid_en), .idex_en(d1_idex_en),
      .exmem_en(d1_exmem_en), .memwb_en(d1_memwb_en), .ifid_flush(d1_ifid_flush),
      .idex_flush(d1_idex_flush), .exmem_flush(d1_exmem_flush),
      .memwb_flush(d1_memwb_flush), .md_busy(d1_md_busy), .stall_cnt(d1_stall_cnt));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected control vector from the effective hazard decisions of a cycle.
   function automatic logic [9:0] expv(input logic mem, input logic md, input logic br,
                                       input logic lu, input logic busy);
      logic hold_front;
      hold_front = mem || md || lu;
      return {!hold_front, !hold_front, !(mem || md), !mem, 1'b1,
              br, br || lu, md && !mem, mem, busy};
   endfunction

   // Model state: an op in EX is tracked by its age in cycles since it started.
   logic m_busy = 0;
   int   m_age  = 0;
   int   m_cnt  = 0;
   int   m1_cnt = 0;
   logic f_start = 0, f_mem = 0, f_stall = 0, f_stall1 = 0;

   always @(negedge clk) begin
      logic mem, lu_raw, start, md, br, lu, br1, lu1;
      mem    = mem_req && !mem_ready;
      lu_raw = ex_mem_read && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (!m_busy) begin
         start = ex_md_start && !mem && (MDC > 1);
         md    = start;
         br    = ex_branch_taken && !mem && !start;
         lu    = lu_raw && !mem && !start && !br;
      end else begin
         start = 0;
         md    = (m_age < MDC - 1);
         br    = 0;
         lu    = 0;
      end
      br1 = ex_branch_taken && !mem;
      lu1 = lu_raw && !mem && !br1;
      chk("ctrl", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
                       idex_flush, exmem_flush, memwb_flush, md_busy}),
          32'(expv(mem, md, br, lu, m_busy)));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("md1_ctrl", 32'({d1_pc_en, d1_ifid_en, d1_idex_en, d1_exmem_en, d1_memwb_en,
                           d1_ifid_flush, d1_idex_flush, d1_exmem_flush, d1_memwb_flush,
                           d1_md_busy}),
          32'(expv(mem, 1'b0, br1, lu1, 1'b0)));
      chk("md1_stall_cnt", 32'(d1_stall_cnt), 32'(m1_cnt));
      f_start  = start;
      f_mem    = mem;
      f_stall  = mem || md || lu;
      f_stall1 = mem || lu1;
   end

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_busy = 0; m_age = 0; m_cnt = 0; m1_cnt = 0;
      end else begin
         if (m_busy) begin
            if (m_age >= MDC - 1 && !f_mem) m_busy = 0;
            else m_age++;
         end else if (f_start) begin
            m_busy = 1; m_age = 1;
         end
         m_cnt  = stat_clr ? 0 : ((f_stall  && m_cnt  < CMAX) ? m_cnt + 1  : m_cnt);
         m1_cnt = stat_clr ? 0 : ((f_stall1 && m1_cnt < CMAX) ? m1_cnt + 1 : m1_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0; ex_mem_read = 0;
      ex_branch_taken = 0; ex_md_start = 0; mem_req = 0; mem_ready = 0; stat_clr = 0;
   endtask

   task automatic clear_cnt();
      idle();
      stat_clr = 1;
      tick();
      stat_clr = 0;
   endtask

   // {ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, bubble expected}
   typedef struct {logic rd; logic [4:0] ert; logic [4:0] rs; logic [4:0] rt; logic urt; logic bub;} lu_vec_t;
   lu_vec_t luv[6] = '{
      '{1, 5'd5, 5'd5, 5'd0, 0, 1}, '{1, 5'd0, 5'd0, 5'd0, 1, 0},
      '{1, 5'd7, 5'd3, 5'd7, 1, 1}, '{1, 5'd7, 5'd3, 5'd7, 0, 0},
      '{0, 5'd5, 5'd5, 5'd5, 1, 0}, '{1, 5'd9, 5'd9, 5'd9, 1, 1}};

   initial begin
      #1 resetN = 0;
      repeat (3) tick();
      chk("rst_md_busy", 32'(md_busy), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_pc_en", 32'(pc_en), 32'd1);
      resetN = 1;
      tick();

      // Load-use bubble table
      for (int i = 0; i < 6; i++) begin
         ex_mem_read = luv[i].rd; ex_rt = luv[i].ert; id_rs = luv[i].rs;
         id_rt = luv[i].rt; id_uses_rt = luv[i].urt;
         #1;
         chk("lu_pc_en", 32'(pc_en), 32'(!luv[i].bub));
         chk("lu_idex_flush", 32'(idex_flush), 32'(luv[i].bub));
         tick();
         idle();
         if (i == 0) begin
            #1 chk("lu_cnt_1", 32'(stall_cnt), 32'd1);
         end
      end

      // Mul/div occupancy, MD_CYCLES=4
      clear_cnt();
      ex_md_start = 1;
      #1;
      chk("md_c1_exmem_flush", 32'(exmem_flush), 32'd1);
      chk("md_c1_busy", 32'(md_busy), 32'd0);
      chk("md1_c1_pc_en", 32'(d1_pc_en), 32'd1);
      tick();
      chk("md_c2_busy", 32'(md_busy), 32'd1);
      chk("md_c2_exmem_flush", 32'(exmem_flush), 32'd1);
      tick();
      chk("md_c3_exmem_flush", 32'(exmem_flush), 32'd1);
      tick();
      chk("md_c4_exmem_flush", 32'(exmem_flush), 32'd0);
      chk("md_c4_pc_en", 32'(pc_en), 32'd1);
      ex_md_start = 0;
      tick();
      chk("md_done_busy", 32'(md_busy), 32'd0);
      chk("md_cnt_3", 32'(stall_cnt), 32'd3);
      chk("md1_busy", 32'(d1_md_busy), 32'd0);

      // Memory wait masks a taken branch until ready
      ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("memw_pc_en", 32'(pc_en), 32'd0);
         chk("memw_memwb_flush", 32'(memwb_flush), 32'd1);
         chk("memw_ifid_flush", 32'(ifid_flush), 32'd0);
         tick();
      end
      mem_ready = 1;
      #1;
      chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("br_idex_flush", 32'(idex_flush), 32'd1);
      chk("br_pc_en", 32'(pc_en), 32'd1);
      tick();
      idle();

      // Memory wait spanning the end of a mul/div (wait in cycles 3..5)
      ex_md_start = 1;
      tick();
      ex_md_start = 0;
      tick();
      mem_req = 1; mem_ready = 0;
      #1 chk("mdm_c3_exmem_flush", 32'(exmem_flush), 32'd0);
      tick(); tick();
      chk("mdm_c5_busy", 32'(md_busy), 32'd1);
      tick();
      mem_ready = 1;
      #1 chk("mdm_c6_busy", 32'(md_busy), 32'd1);
      tick();
      chk("mdm_run", 32'(md_busy), 32'd0);
      idle();

      // Asynchronous reset in the middle of MD_BUSY
      ex_md_start = 1;
      tick(); tick();
      #1;
      idle();
      resetN = 0;
      #1;
      chk("arst_md_busy", 32'(md_busy), 32'd0);
      chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("arst_pc_en", 32'(pc_en), 32'd1);
      tick();
      resetN = 1;
      tick();

      // Saturation and clear-over-increment
      mem_req = 1; mem_ready = 0;
      repeat (CMAX + 3) tick();
      chk("sat_hold", 32'(stall_cnt), 32'(CMAX));
      stat_clr = 1;
      tick();
      stat_clr = 0;
      #1 chk("clr_wins", 32'(stall_cnt), 32'd0);
      idle();
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
